mgc_ace_snoop_responder: RTL and testbench

MGC_ACE_SNOOP_RESPONDER -- requirements
Module: mgc_ace_snoop_responder

---
 rtl/mgc_ace_pkg.sv | 64 ++++++
 rtl/mgc_ace_crresp_decode.sv | 19 +
 rtl/mgc_ace_snoop_responder.sv | 164 ++++++++++++++++
 tb/tb_mgc_ace_snoop_responder.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mgc_ace_pkg.sv
// Shared definitions for the ACE snoop responder: snoop encodings, CRRESP bit
// positions, the responder state enum and the snoop response decode rules.
package mgc_ace_pkg;

  localparam logic [3:0] SNP_READ_ONCE             = 4'b0000;
  localparam logic [3:0] SNP_READ_SHARED           = 4'b0001;
  localparam logic [3:0] SNP_READ_CLEAN            = 4'b0010;
  localparam logic [3:0] SNP_READ_NOT_SHARED_DIRTY = 4'b0011;
  localparam logic [3:0] SNP_READ_UNIQUE           = 4'b0111;
  localparam logic [3:0] SNP_CLEAN_SHARED          = 4'b1000;
  localparam logic [3:0] SNP_CLEAN_INVALID         = 4'b1001;
  localparam logic [3:0] SNP_MAKE_INVALID          = 4'b1101;
  localparam logic [3:0] SNP_DVM_COMPLETE          = 4'b1110;
  localparam logic [3:0] SNP_DVM_MESSAGE           = 4'b1111;

  localparam int CR_DATA_XFER  = 0;
  localparam int CR_ERROR      = 1;
  localparam int CR_PASS_DIRTY = 2;
  localparam int CR_IS_SHARED  = 3;
  localparam int CR_WAS_UNIQUE = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_RESP,
    ST_DATA
  } state_e;

  // DVM and undefined codes fall through to an all-zero response; Error is never set.
  function automatic logic [4:0] crresp_decode(input logic [3:0] snoop,
                                               input logic       hit,
                                               input logic       dirty,
                                               input logic       uniq);
    logic [4:0] r;
    r = '0;
    if (hit) begin
      case (snoop)
        SNP_READ_ONCE, SNP_READ_SHARED, SNP_READ_CLEAN,
        SNP_READ_NOT_SHARED_DIRTY, SNP_READ_UNIQUE: begin
          r[CR_DATA_XFER]  = 1'b1;
          r[CR_WAS_UNIQUE] = uniq;
          r[CR_IS_SHARED]  = (snoop != SNP_READ_UNIQUE);
          r[CR_PASS_DIRTY] = dirty && (snoop != SNP_READ_ONCE);
        end
        SNP_CLEAN_SHARED, SNP_CLEAN_INVALID: begin
          r[CR_DATA_XFER]  = dirty;
          r[CR_PASS_DIRTY] = dirty;
          r[CR_IS_SHARED]  = (snoop == SNP_CLEAN_SHARED);
          r[CR_WAS_UNIQUE] = uniq;
        end
        SNP_MAKE_INVALID: r[CR_WAS_UNIQUE] = uniq;
        default: r = '0;
      endcase
    end
    r[CR_ERROR] = 1'b0;
    return r;
  endfunction

  function automatic logic snoop_invalidates(input logic [3:0] snoop, input logic hit);
    return hit && ((snoop == SNP_READ_UNIQUE) || (snoop == SNP_CLEAN_INVALID) ||
                   (snoop == SNP_MAKE_INVALID));
  endfunction

endpackage

// File: rtl/mgc_ace_crresp_decode.sv
// Combinational snoop response decode: maps snoop type and cache lookup
// result to CRRESP and the line invalidate request.
module mgc_ace_crresp_decode
  import mgc_ace_pkg::*;
(
  input  logic [3:0] snoop,
  input  logic       hit,
  input  logic       dirty,
  input  logic       uniq,
  output logic [4:0] crresp,
  output logic       inv
);

  always_comb begin
    crresp = crresp_decode(snoop, hit, dirty, uniq);
    inv    = snoop_invalidates(snoop, hit);
  end

endmodule

// File: rtl/mgc_ace_snoop_responder.sv
// ACE snoop responder: accepts one snoop at a time, looks the line up in the
// cache, returns CRRESP and, when DataTransfer is set, streams the line on CD.
module mgc_ace_snoop_responder
  import mgc_ace_pkg::*;
#(
  parameter  int ADDR_WIDTH  = 32,
  parameter  int SDATA_WIDTH = 64,
  parameter  int LINE_BYTES  = 64,
  localparam int BEATS       = LINE_BYTES * 8 / SDATA_WIDTH,
  localparam int BEAT_W      = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                   ACLK,
  input  logic                   ARESET,
  input  logic                   ACVALID,
  output logic                   ACREADY,
  input  logic [ADDR_WIDTH-1:0]  ACADDR,
  input  logic [3:0]             ACSNOOP,
  input  logic [2:0]             ACPROT,
  output logic                   CRVALID,
  input  logic                   CRREADY,
  output logic [4:0]             CRRESP,
  output logic                   CDVALID,
  input  logic                   CDREADY,
  output logic [SDATA_WIDTH-1:0] CDDATA,
  output logic                   CDLAST,
  output logic                   lk_req,
  output logic [ADDR_WIDTH-1:0]  lk_addr,
  input  logic                   lk_rsp_valid,
  input  logic                   lk_hit,
  input  logic                   lk_dirty,
  input  logic                   lk_unique,
  output logic [BEAT_W-1:0]      rd_beat,
  input  logic [SDATA_WIDTH-1:0] rd_data,
  output logic                   inv_pulse,
  output state_e                 dbg_state,
  output logic [3:0]             dbg_snoop,
  output logic [2:0]             dbg_prot
);

  localparam int                    OFF       = $clog2(LINE_BYTES);
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {ADDR_WIDTH{1'b1}} << OFF;
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(BEATS - 1);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]              snoop_q, snoop_d;
  logic [2:0]              prot_q, prot_d;
  logic [4:0]              crresp_q, crresp_d;
  logic                    inv_q, inv_d;
  logic [BEAT_W-1:0]       beat_q, beat_d;
  logic                    lk_req_q, lk_req_d;
  logic [4:0]              dec_crresp;
  logic                    dec_inv;
  logic                    ac_hs, cr_hs, cd_hs, last_beat;

  // All channels: a transfer happens on a rising edge where VALID && READY;
  // VALID and its payload are held stable by this block until that edge.
  assign ac_hs     = ACVALID && ACREADY;
  assign cr_hs     = CRVALID && CRREADY;
  assign cd_hs     = CDVALID && CDREADY;
  assign last_beat = (beat_q == LAST_BEAT);

  mgc_ace_crresp_decode u_decode (
    .snoop  (snoop_q),
    .hit    (lk_hit),
    .dirty  (lk_dirty),
    .uniq   (lk_unique),
    .crresp (dec_crresp),
    .inv    (dec_inv)
  );

  always_ff @(posedge ACLK) begin
    if (ARESET) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (ac_hs) state_d = ST_LOOKUP;
      ST_LOOKUP: if (lk_rsp_valid) state_d = ST_RESP;
      ST_RESP:   if (cr_hs) state_d = crresp_q[CR_DATA_XFER] ? ST_DATA : ST_IDLE;
      ST_DATA:   if (cd_hs && last_beat) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Reset gates every handshake output so an abandoned snoop issues nothing.
  always_comb begin
    ACREADY   = 1'b0;
    CRVALID   = 1'b0;
    CRRESP    = '0;
    CDVALID   = 1'b0;
    CDLAST    = 1'b0;
    CDDATA    = '0;
    lk_req    = 1'b0;
    inv_pulse = 1'b0;
    if (!ARESET) begin
      lk_req = lk_req_q;
      case (state_q)
        ST_IDLE: ACREADY = 1'b1;
        ST_RESP: begin
          CRVALID   = 1'b1;
          CRRESP    = crresp_q;
          inv_pulse = inv_q && CRREADY;
        end
        ST_DATA: begin
          CDVALID = 1'b1;
          CDDATA  = rd_data;
          CDLAST  = last_beat;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    addr_d   = addr_q;
    snoop_d  = snoop_q;
    prot_d   = prot_q;
    crresp_d = crresp_q;
    inv_d    = inv_q;
    beat_d   = beat_q;
    lk_req_d = 1'b0;
    if (ac_hs) begin
      addr_d   = ACADDR;
      snoop_d  = ACSNOOP;
      prot_d   = ACPROT;
      lk_req_d = 1'b1;
    end
    if ((state_q == ST_LOOKUP) && lk_rsp_valid) begin
      crresp_d = dec_crresp;
      inv_d    = dec_inv;
    end
    if (cd_hs) beat_d = last_beat ? '0 : beat_q + BEAT_W'(1);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      addr_q   <= '0;
      snoop_q  <= '0;
      prot_q   <= '0;
      crresp_q <= '0;
      inv_q    <= 1'b0;
      beat_q   <= '0;
      lk_req_q <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      snoop_q  <= snoop_d;
      prot_q   <= prot_d;
      crresp_q <= crresp_d;
      inv_q    <= inv_d;
      beat_q   <= beat_d;
      lk_req_q <= lk_req_d;
    end
  end

  assign lk_addr   = addr_q & LINE_MASK;
  assign rd_beat   = beat_q;
  assign dbg_state = state_q;
  assign dbg_snoop = snoop_q;
  assign dbg_prot  = prot_q;

endmodule

// File: tb/tb_mgc_ace_snoop_responder.sv
// Self-checking bench for mgc_ace_snoop_responder: directed vector table,
// a mid-transfer reset sequence and randomized snoops against a response model.
module tb_mgc_ace_snoop_responder;
  import mgc_ace_pkg::*;

  localparam int AW    = 32;
  localparam int DW    = 64;
  localparam int BEATS = 8;

  logic          ACLK = 1'b0;
  logic          ARESET = 1'b1;
  logic          ACVALID, ACREADY;
  logic [AW-1:0] ACADDR;
  logic [3:0]    ACSNOOP;
  logic [2:0]    ACPROT;
  logic          CRVALID, CRREADY;
  logic [4:0]    CRRESP;
  logic          CDVALID, CDREADY;
  logic [DW-1:0] CDDATA;
  logic          CDLAST;
  logic          lk_req;
  logic [AW-1:0] lk_addr;
  logic          lk_rsp_valid, lk_hit, lk_dirty, lk_unique;
  logic [2:0]    rd_beat;
  logic [DW-1:0] rd_data;
  logic          inv_pulse;
  state_e        dbg_state;
  logic [3:0]    dbg_snoop;
  logic [2:0]    dbg_prot;

  logic [DW-1:0] line_mem [BEATS];
  logic [DW-1:0] exp_q [$];
  int            errors = 0;
  int            checks = 0;

  typedef struct {
    logic [3:0] snoop;
    logic       hit, dirty, uniq;
    int         lk_wait, cr_wait, cd_mode, abort_beat;
  } cfg_t;

  typedef struct {
    cfg_t       cfg;
    logic [4:0] exp_resp;
    logic       exp_inv;
  } vec_t;

  mgc_ace_snoop_responder dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ACVALID(ACVALID), .ACREADY(ACREADY), .ACADDR(ACADDR), .ACSNOOP(ACSNOOP), .ACPROT(ACPROT),
    .CRVALID(CRVALID), .CRREADY(CRREADY), .CRRESP(CRRESP),
    .CDVALID(CDVALID), .CDREADY(CDREADY), .CDDATA(CDDATA), .CDLAST(CDLAST),
    .lk_req(lk_req), .lk_addr(lk_addr), .lk_rsp_valid(lk_rsp_valid), .lk_hit(lk_hit),
    .lk_dirty(lk_dirty), .lk_unique(lk_unique),
    .rd_beat(rd_beat), .rd_data(rd_data), .inv_pulse(inv_pulse),
    .dbg_state(dbg_state), .dbg_snoop(dbg_snoop), .dbg_prot(dbg_prot)
  );

  always #5 ACLK = ~ACLK;

  assign rd_data = line_mem[rd_beat];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Response rules written as {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
  function automatic logic [4:0] model_resp(input logic [3:0] s, input logic hit,
                                            input logic d, input logic u);
    logic wu, shared, pd, dt;
    wu = 0; shared = 0; pd = 0; dt = 0;
    if (hit) begin
      if (s inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd7}) begin
        dt = 1; wu = u; shared = (s != 4'd7); pd = (s == 4'd0) ? 1'b0 : d;
      end else if (s == 4'd8 || s == 4'd9) begin
        dt = d; pd = d; shared = (s == 4'd8); wu = u;
      end else if (s == 4'd13) begin
        wu = u;
      end
    end
    return {wu, shared, pd, 1'b0, dt};
  endfunction

  function automatic logic model_inv(input logic [3:0] s, input logic hit);
    return hit && (s == 4'd7 || s == 4'd9 || s == 4'd13);
  endfunction

  function automatic vec_t mk(input logic [3:0] s, input logic h, input logic d, input logic u,
                              input int lkw, input int crw, input int cdm,
                              input logic [4:0] r, input logic inv);
    vec_t v;
    v.cfg = '{snoop: s, hit: h, dirty: d, uniq: u, lk_wait: lkw, cr_wait: crw,
              cd_mode: cdm, abort_beat: -1};
    v.exp_resp = r;
    v.exp_inv  = inv;
    return v;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, ".ctl_zero"}, {ACREADY, CRVALID, CDVALID, CDLAST, lk_req, inv_pulse, CRRESP}, 0);
    check({tag, ".cddata_zero"}, CDDATA, 0);
  endtask

  // One complete snoop: AC handshake, lookup reply, CR phase, optional CD burst.
  task automatic run_snoop(input cfg_t c, input logic [4:0] er, input logic ei, input string tag);
    logic [AW-1:0] addr;
    logic [2:0]    prot;
    int            idx;
    addr = $urandom;
    prot = 3'($urandom_range(0, 7));
    for (int b = 0; b < BEATS; b++) line_mem[b] = {$urandom, $urandom};

    @(negedge ACLK);
    ACVALID = 1; ACADDR = addr; ACSNOOP = c.snoop; ACPROT = prot;
    #1 check({tag, ".acready"}, ACREADY, 1);

    @(negedge ACLK);
    ACVALID = 0; ACADDR = $urandom; ACSNOOP = 4'($urandom); ACPROT = 3'($urandom);
    #1;
    check({tag, ".lk_req"}, lk_req, 1);
    check({tag, ".lk_addr"}, lk_addr, {addr[AW-1:6], 6'b0});
    check({tag, ".acready_busy"}, ACREADY, 0);
    check({tag, ".cap_snoop"}, dbg_snoop, c.snoop);
    check({tag, ".cap_prot"}, dbg_prot, prot);

    for (int d = 1; d <= c.lk_wait; d++) begin
      @(negedge ACLK);
      lk_rsp_valid = (d == c.lk_wait);
      if (lk_rsp_valid) {lk_hit, lk_dirty, lk_unique} = {c.hit, c.dirty, c.uniq};
      else              {lk_hit, lk_dirty, lk_unique} = 3'($urandom);
      #1;
      check({tag, ".lk_req_once"}, lk_req, 0);
      check({tag, ".crvalid_early"}, CRVALID, 0);
    end

    for (int w = 0; w <= c.cr_wait; w++) begin
      @(negedge ACLK);
      lk_rsp_valid = 0;
      {lk_hit, lk_dirty, lk_unique} = 3'($urandom);
      CRREADY = (w == c.cr_wait);
      #1;
      check({tag, ".crvalid"}, CRVALID, 1);
      check({tag, ".crresp"}, CRRESP, er);
      check({tag, ".inv_pulse"}, inv_pulse, (w == c.cr_wait) ? ei : 1'b0);
      check({tag, ".cdvalid_in_cr"}, CDVALID, 0);
    end

    @(negedge ACLK);
    CRREADY = 0;
    if (er[0]) begin
      for (int b = 0; b < BEATS; b++) exp_q.push_back(line_mem[b]);
      idx = 0;
      for (int cyc = 0; cyc < 64 && exp_q.size() > 0; cyc++) begin
        if (cyc > 0) @(negedge ACLK);
        if (c.abort_beat == idx) begin
          ARESET = 1; CDREADY = 1;
          @(negedge ACLK);
          #1;
          check_all_zero({tag, ".in_reset"});
          check({tag, ".reset_state"}, dbg_state, ST_IDLE);
          check({tag, ".reset_beat"}, rd_beat, 0);
          @(negedge ACLK);
          ARESET = 0; CDREADY = 0;
          #1;
          check({tag, ".acready_after_reset"}, ACREADY, 1);
          check({tag, ".cdvalid_after_reset"}, CDVALID, 0);
          exp_q.delete();
          return;
        end
        case (c.cd_mode)
          0:       CDREADY = 1;
          1:       CDREADY = (cyc % 2 == 1);
          default: CDREADY = 1'($urandom_range(0, 1));
        endcase
        #1;
        check({tag, ".cdvalid"}, CDVALID, 1);
        check({tag, ".rd_beat"}, rd_beat, idx[2:0]);
        check({tag, ".cdlast"}, CDLAST, (idx == BEATS - 1));
        check({tag, ".cddata"}, CDDATA, exp_q[0]);
        check({tag, ".crvalid_in_cd"}, CRVALID, 0);
        if (CDVALID && CDREADY) begin
          void'(exp_q.pop_front());
          idx++;
        end
      end
      check({tag, ".beats_left"}, exp_q.size(), 0);
      exp_q.delete();
      @(negedge ACLK);
      CDREADY = 0;
    end
    #1;
    check({tag, ".acready_back"}, ACREADY, 1);
    check({tag, ".cdvalid_idle"}, CDVALID, 0);
    check({tag, ".crvalid_idle"}, CRVALID, 0);
  endtask

  vec_t vecs [14];
  cfg_t rc;

  initial begin
    ACVALID = 0; ACADDR = '0; ACSNOOP = '0; ACPROT = '0;
    CRREADY = 0; CDREADY = 0;
    lk_rsp_valid = 0; lk_hit = 0; lk_dirty = 0; lk_unique = 0;
    for (int b = 0; b < BEATS; b++) line_mem[b] = '0;

    repeat (3) @(negedge ACLK);
    #1;
    check_all_zero("reset");
    check("reset.state", dbg_state, ST_IDLE);
    @(negedge ACLK);
    ARESET = 0;
    #1 check("reset.acready_release", ACREADY, 1);

    //            snoop  h  d  u  lkw crw cdm resp      inv
    vecs[0]  = mk(4'd1,  0, 0, 0, 1,  0,  0,  5'b00000, 0);
    vecs[1]  = mk(4'd7,  1, 1, 1, 1,  0,  0,  5'b10101, 1);
    vecs[2]  = mk(4'd7,  1, 1, 1, 2,  5,  1,  5'b10101, 1);
    vecs[3]  = mk(4'd0,  1, 1, 0, 1,  0,  0,  5'b01001, 0);
    vecs[4]  = mk(4'd15, 1, 1, 1, 1,  0,  0,  5'b00000, 0);
    vecs[5]  = mk(4'd13, 1, 0, 1, 1,  0,  0,  5'b10000, 1);
    vecs[6]  = mk(4'd8,  1, 1, 0, 1,  1,  2,  5'b01101, 0);
    vecs[7]  = mk(4'd9,  1, 0, 1, 3,  0,  0,  5'b10000, 1);
    vecs[8]  = mk(4'd2,  1, 0, 1, 1,  2,  1,  5'b11001, 0);
    vecs[9]  = mk(4'd3,  1, 1, 0, 1,  0,  2,  5'b01101, 0);
    vecs[10] = mk(4'd4,  1, 1, 1, 1,  0,  0,  5'b00000, 0);
    vecs[11] = mk(4'd7,  0, 1, 1, 1,  0,  0,  5'b00000, 0);
    vecs[12] = mk(4'd13, 1, 1, 0, 1,  0,  0,  5'b00000, 1);
    vecs[13] = mk(4'd14, 1, 0, 0, 1,  0,  0,  5'b00000, 0);

    for (int i = 0; i < 14; i++)
      run_snoop(vecs[i].cfg, vecs[i].exp_resp, vecs[i].exp_inv, $sformatf("vec%0d", i));

    // Reset while beat 3 of a ReadShared burst is on the bus, then a clean snoop.
    rc = '{snoop: 4'd1, hit: 1, dirty: 1, uniq: 0, lk_wait: 1, cr_wait: 0, cd_mode: 0,
           abort_beat: 3};
    run_snoop(rc, 5'b01101, 0, "abort");
    rc = '{snoop: 4'd7, hit: 1, dirty: 0, uniq: 1, lk_wait: 1, cr_wait: 1, cd_mode: 2,
           abort_beat: -1};
    run_snoop(rc, 5'b10001, 1, "post_abort");

    for (int n = 0; n < 40; n++) begin
      rc.snoop      = 4'($urandom_range(0, 15));
      rc.hit        = 1'($urandom_range(0, 1));
      rc.dirty      = 1'($urandom_range(0, 1));
      rc.uniq       = 1'($urandom_range(0, 1));
      rc.lk_wait    = $urandom_range(1, 3);
      rc.cr_wait    = $urandom_range(0, 3);
      rc.cd_mode    = $urandom_range(0, 2);
      rc.abort_beat = -1;
      run_snoop(rc, model_resp(rc.snoop, rc.hit, rc.dirty, rc.uniq),
                model_inv(rc.snoop, rc.hit), $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
